// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX FIFO reader.
//   - tx_state_e : serializer FSM states
//   - PAR_*      : encoding of the PARITY parameter
//   - DATA_WIDTH : payload bits per frame
//   - parity_bit : parity bit for a payload under a given parity mode
package uart_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Even parity makes the total count of ones even, so the bit is the XOR of
  // the payload; odd parity is its inverse. PAR_NONE returns the even value,
  // which is simply never driven onto the line.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                      input int unsigned mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_reader_if.sv
// Read port of the 8-entry byte FIFO as seen by the UART transmitter.
//   fifo_empty : FIFO empty flag
//   fifo_data  : registered FIFO output, updated on the edge a read is accepted
//   fifo_rd_en : read enable, one cycle per byte
// master = the reader (transmitter), slave = the FIFO.
interface uart_tx_fifo_reader_if;
  import uart_pkg::*;

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer. Counts clock cycles 0..CLKS_PER_BIT-1 and flags the last
// cycle of each bit period. Wraps to 0 after the last cycle so consecutive
// bits are back to back; clear holds the count at 0.
//   clk     : system clock
//   reset   : synchronous, active-high reset
//   clear   : synchronous clear, held by the FSM outside timed states
//   bit_end : high in the last cycle of the current bit period
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end = (cnt_q == LastCnt);
    cnt_d   = cnt_q + CntW'(1);
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// Drains the byte FIFO and serializes each byte onto a UART TX line:
// start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high reset
//   enable  : permits fetching new bytes from the FIFO
//   fifo    : FIFO read port (empty flag, registered data, read enable)
//   tx      : serial line, idle high
//   busy    : high from FETCH through the last stop-bit cycle
//   tx_done : one-cycle pulse in the last cycle of the final stop bit
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  uart_tx_fifo_reader_if.master        fifo,
  output logic                         tx,
  output logic                         busy,
  output logic                         tx_done
);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  // Data bit index in StData, stop bit index in StStop.
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  timer_clr;
  logic                  bit_end;
  logic                  last_stop;
  logic                  byte_ready;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clr),
    .bit_end(bit_end)
  );

  assign last_stop  = (bit_cnt_q == 3'(STOP_BITS - 1));
  assign byte_ready = enable && !fifo.fifo_empty;

  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    par_d           = par_q;
    bit_cnt_d       = bit_cnt_q;
    tx              = 1'b1;
    busy            = 1'b1;
    tx_done         = 1'b0;
    timer_clr       = 1'b0;
    fifo.fifo_rd_en = 1'b0;

    case (state_q)
      StIdle: begin
        busy      = 1'b0;
        timer_clr = 1'b1;
        if (byte_ready) begin
          state_d = StFetch;
        end
      end

      StFetch: begin
        // Gated so a read is never issued in the cycle reset is applied.
        fifo.fifo_rd_en = !reset;
        timer_clr       = 1'b1;
        state_d         = StLoad;
      end

      StLoad: begin
        // The FIFO presented the fetched byte on the edge closing StFetch.
        timer_clr = 1'b1;
        shift_d   = fifo.fifo_data;
        par_d     = parity_bit(fifo.fifo_data, PARITY);
        bit_cnt_d = '0;
        state_d   = StStart;
      end

      StStart: begin
        tx = 1'b0;
        if (bit_end) begin
          state_d = StData;
        end
      end

      StData: begin
        tx = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      StParity: begin
        tx = par_q;
        if (bit_end) begin
          state_d = StStop;
        end
      end

      StStop: begin
        if (bit_end) begin
          if (last_stop) begin
            tx_done   = 1'b1;
            bit_cnt_d = '0;
            state_d   = byte_ready ? StFetch : StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader. Three instances, all CLKS_PER_BIT=4:
//   dut 0: no parity, 1 stop bit
//   dut 1: even parity, 2 stop bits
//   dut 2: odd parity, 1 stop bit
// Each instance reads from a small behavioural 8-entry FIFO.
module tb_uart_tx_fifo_reader;
  import uart_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] en    = '0;

  logic [2:0] tx_v, busy_v, done_v, rd_v, empty_v;

  logic [7:0]  mem [3][8];
  int unsigned wr_cnt [3] = '{default: 0};
  int unsigned rd_cnt [3] = '{default: 0};
  logic [7:0]  fdata  [3] = '{default: 8'h00};
  logic [2:0]  rd_when_empty = '0;

  int total = 0;
  int bad   = 0;

  logic tr_tx   [200];
  logic tr_rd   [200];
  logic tr_busy [200];
  logic tr_done [200];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned Par = (k == 1) ? PAR_EVEN : ((k == 2) ? PAR_ODD : PAR_NONE);
    localparam int unsigned Sb  = (k == 1) ? 2 : 1;

    uart_tx_fifo_reader_if f_if ();

    assign f_if.fifo_empty = (wr_cnt[k] == rd_cnt[k]);
    assign f_if.fifo_data  = fdata[k];
    assign rd_v[k]         = f_if.fifo_rd_en;
    assign empty_v[k]      = f_if.fifo_empty;

    uart_tx_fifo_reader #(
      .CLKS_PER_BIT(4),
      .PARITY      (Par),
      .STOP_BITS   (Sb)
    ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .enable (en[k]),
      .fifo   (f_if),
      .tx     (tx_v[k]),
      .busy   (busy_v[k]),
      .tx_done(done_v[k])
    );
  end

  // FIFO model: data register updates on the edge the read is accepted.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd_v[k]) begin
        if (wr_cnt[k] == rd_cnt[k]) begin
          rd_when_empty[k] <= 1'b1;
        end else begin
          fdata[k]  <= mem[k][rd_cnt[k][2:0]];
          rd_cnt[k] <= rd_cnt[k] + 1;
        end
      end
    end
  end

  task automatic push(input int k, input logic [7:0] b);
    mem[k][wr_cnt[k][2:0]] = b;
    wr_cnt[k] = wr_cnt[k] + 1;
  endtask

  // Records outputs of instance k at the next n falling edges (index 1..n).
  task automatic trace(input int k, input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      tr_tx[i]   = tx_v[k];
      tr_rd[i]   = rd_v[k];
      tr_busy[i] = busy_v[k];
      tr_done[i] = done_v[k];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (tx_v !== 3'b111) begin bad++; $display("FAIL reset_tx: got %b want 111", tx_v); end
    total++; if (busy_v !== 3'b000) begin bad++; $display("FAIL reset_busy: got %b want 000", busy_v); end
    total++; if (done_v !== 3'b000) begin bad++; $display("FAIL reset_done: got %b want 000", done_v); end
    total++; if (rd_v !== 3'b000) begin bad++; $display("FAIL reset_rd: got %b want 000", rd_v); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (tx_v !== 3'b111) begin bad++; $display("FAIL post_reset_tx: got %b want 111", tx_v); end
  endtask

  task automatic test_single();
    logic [9:0] frame;
    logic       e_tx;
    frame = 10'b1101001010;  // 0xA5 framed, bit 0 sent first
    push(0, 8'hA5);
    en[0] = 1'b1;
    trace(0, 46);
    en[0] = 1'b0;
    for (int i = 1; i <= 46; i++) begin
      e_tx = (i >= 3 && i <= 42) ? frame[(i - 3) / 4] : 1'b1;
      total++; if (tr_tx[i] !== e_tx) begin bad++; $display("FAIL single_tx[%0d]: got %b want %b", i, tr_tx[i], e_tx); end
      total++; if (tr_rd[i] !== (i == 1)) begin bad++; $display("FAIL single_rd[%0d]: got %b want %b", i, tr_rd[i], (i == 1)); end
      total++; if (tr_done[i] !== (i == 42)) begin bad++; $display("FAIL single_done[%0d]: got %b want %b", i, tr_done[i], (i == 42)); end
      total++; if (tr_busy[i] !== (i <= 42)) begin bad++; $display("FAIL single_busy[%0d]: got %b want %b", i, tr_busy[i], (i <= 42)); end
    end
  endtask

  task automatic test_back_to_back();
    logic e_tx;
    int   pulses;
    push(0, 8'h00);
    push(0, 8'hFF);
    en[0] = 1'b1;
    trace(0, 90);
    en[0] = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 90; i++) begin
      if (i >= 3 && i <= 42)      e_tx = ((i - 3) / 4 == 9);
      else if (i >= 45 && i <= 84) e_tx = ((i - 45) / 4 != 0);
      else                         e_tx = 1'b1;
      if (tr_rd[i] === 1'b1) pulses++;
      total++; if (tr_tx[i] !== e_tx) begin bad++; $display("FAIL b2b_tx[%0d]: got %b want %b", i, tr_tx[i], e_tx); end
      total++; if (tr_rd[i] !== (i == 1 || i == 43)) begin bad++; $display("FAIL b2b_rd[%0d]: got %b", i, tr_rd[i]); end
      total++; if (tr_done[i] !== (i == 42 || i == 84)) begin bad++; $display("FAIL b2b_done[%0d]: got %b", i, tr_done[i]); end
    end
    total++; if (pulses != 2) begin bad++; $display("FAIL b2b_rd_pulses: got %0d want 2", pulses); end
    total++; if (empty_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_empty: got %b want 1", empty_v[0]); end
  endtask

  task automatic test_parity();
    logic [11:0] f_even;
    logic [10:0] f_odd;
    logic        e_tx;
    f_even = 12'b111000001110;  // 0x07, parity 1, two stop bits
    f_odd  = 11'b10000001110;   // 0x07, parity 0, one stop bit
    push(1, 8'h07);
    en[1] = 1'b1;
    trace(1, 54);
    en[1] = 1'b0;
    for (int i = 1; i <= 54; i++) begin
      e_tx = (i >= 3 && i <= 50) ? f_even[(i - 3) / 4] : 1'b1;
      total++; if (tr_tx[i] !== e_tx) begin bad++; $display("FAIL even_tx[%0d]: got %b want %b", i, tr_tx[i], e_tx); end
      total++; if (tr_done[i] !== (i == 50)) begin bad++; $display("FAIL even_done[%0d]: got %b", i, tr_done[i]); end
      total++; if (tr_busy[i] !== (i <= 50)) begin bad++; $display("FAIL even_busy[%0d]: got %b", i, tr_busy[i]); end
    end
    push(2, 8'h07);
    en[2] = 1'b1;
    trace(2, 50);
    en[2] = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      e_tx = (i >= 3 && i <= 46) ? f_odd[(i - 3) / 4] : 1'b1;
      total++; if (tr_tx[i] !== e_tx) begin bad++; $display("FAIL odd_tx[%0d]: got %b want %b", i, tr_tx[i], e_tx); end
      total++; if (tr_done[i] !== (i == 46)) begin bad++; $display("FAIL odd_done[%0d]: got %b", i, tr_done[i]); end
    end
  endtask

  task automatic test_empty_enable();
    logic [9:0] frame;
    logic       e_tx;
    int         j;
    total++; if (empty_v[0] !== 1'b1) begin bad++; $display("FAIL empty_pre: got %b want 1", empty_v[0]); end
    en[0] = 1'b1;
    trace(0, 20);
    en[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      total++; if (tr_rd[i] !== 1'b0) begin bad++; $display("FAIL empty_rd[%0d]: got %b want 0", i, tr_rd[i]); end
      total++; if (tr_tx[i] !== 1'b1) begin bad++; $display("FAIL empty_tx[%0d]: got %b want 1", i, tr_tx[i]); end
    end
    frame = 10'b1000100010;  // 0x11 framed
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    en[0] = 1'b1;
    trace(0, 10);
    total++; if (tr_rd[1] !== 1'b1) begin bad++; $display("FAIL drop_first_rd: got %b want 1", tr_rd[1]); end
    en[0] = 1'b0;  // dropped during the data bits
    trace(0, 40);
    for (int i = 1; i <= 40; i++) begin
      j = i + 10;
      e_tx = (j <= 42) ? frame[(j - 3) / 4] : 1'b1;
      total++; if (tr_tx[i] !== e_tx) begin bad++; $display("FAIL drop_tx[%0d]: got %b want %b", j, tr_tx[i], e_tx); end
      total++; if (tr_rd[i] !== 1'b0) begin bad++; $display("FAIL drop_rd[%0d]: got %b want 0", j, tr_rd[i]); end
      total++; if (tr_done[i] !== (j == 42)) begin bad++; $display("FAIL drop_done[%0d]: got %b", j, tr_done[i]); end
      total++; if (tr_busy[i] !== (j <= 42)) begin bad++; $display("FAIL drop_busy[%0d]: got %b", j, tr_busy[i]); end
    end
    total++;
    if (wr_cnt[0] - rd_cnt[0] != 2) begin
      bad++; $display("FAIL drop_left: got %0d want 2", wr_cnt[0] - rd_cnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] frame;
    logic       e_tx;
    frame = 10'b1001100110;  // 0x33 framed
    en[0] = 1'b1;
    trace(0, 24);  // cycle 24 lies in data bit 4 of 0x22
    total++; if (tr_busy[24] !== 1'b1) begin bad++; $display("FAIL rmid_busy_pre: got %b want 1", tr_busy[24]); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (tx_v[0] !== 1'b1) begin bad++; $display("FAIL rmid_tx[%0d]: got %b want 1", i, tx_v[0]); end
      total++; if (rd_v[0] !== 1'b0) begin bad++; $display("FAIL rmid_rd[%0d]: got %b want 0", i, rd_v[0]); end
      total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL rmid_busy[%0d]: got %b want 0", i, busy_v[0]); end
    end
    reset = 1'b0;
    trace(0, 46);
    en[0] = 1'b0;
    for (int i = 1; i <= 46; i++) begin
      e_tx = (i >= 3 && i <= 42) ? frame[(i - 3) / 4] : 1'b1;
      total++; if (tr_tx[i] !== e_tx) begin bad++; $display("FAIL rmid_frame_tx[%0d]: got %b want %b", i, tr_tx[i], e_tx); end
      total++; if (tr_rd[i] !== (i == 1)) begin bad++; $display("FAIL rmid_frame_rd[%0d]: got %b", i, tr_rd[i]); end
      total++; if (tr_done[i] !== (i == 42)) begin bad++; $display("FAIL rmid_frame_done[%0d]: got %b", i, tr_done[i]); end
    end
    total++; if (empty_v[0] !== 1'b1) begin bad++; $display("FAIL rmid_empty: got %b want 1", empty_v[0]); end
  endtask

  task automatic test_wrap();
    logic [7:0] wexp [20];
    logic [7:0] rx_byte;
    int         pushed, nrx, ph, cyc;
    logic       rx_act;
    for (int j = 0; j < 20; j++) wexp[j] = 8'(j * 29 + 3);
    pushed = 0;
    for (int j = 0; j < 8; j++) begin
      push(0, wexp[pushed]);
      pushed++;
    end
    en[0]   = 1'b1;
    nrx     = 0;
    ph      = 0;
    rx_act  = 1'b0;
    rx_byte = '0;
    cyc     = 0;
    while (nrx < 20 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!rx_act) begin
        if (tx_v[0] === 1'b0) begin
          rx_act = 1'b1;
          ph     = 0;
        end
      end else begin
        ph++;
      end
      if (rx_act && (ph % 4 == 2)) begin
        if (ph / 4 >= 1 && ph / 4 <= 8) begin
          rx_byte[ph / 4 - 1] = tx_v[0];
        end else if (ph / 4 == 9) begin
          total++; if (tx_v[0] !== 1'b1) begin bad++; $display("FAIL wrap_stop[%0d]: got %b want 1", nrx, tx_v[0]); end
          total++; if (rx_byte !== wexp[nrx]) begin bad++; $display("FAIL wrap_byte[%0d]: got %h want %h", nrx, rx_byte, wexp[nrx]); end
          nrx++;
          rx_act = 1'b0;
        end
      end
      if (pushed < 20 && (wr_cnt[0] - rd_cnt[0]) < 8) begin
        push(0, wexp[pushed]);
        pushed++;
      end
    end
    total++; if (nrx != 20) begin bad++; $display("FAIL wrap_count: got %0d want 20 (timeout)", nrx); end
    repeat (4) @(negedge clk);
    en[0] = 1'b0;
    total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL wrap_busy_end: got %b want 0", busy_v[0]); end
    total++; if (empty_v[0] !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", empty_v[0]); end
    total++; if (rd_when_empty !== 3'b000) begin bad++; $display("FAIL rd_while_empty: got %b want 000", rd_when_empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_empty_enable();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
Read side of the 8-entry byte FIFO buffer. Drains the FIFO through its read port (read enable, empty flag, registered data out) and serializes each byte onto a UART TX line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits. Sits between the FIFO buffer and the TX pad. Bit timing comes from a clocks-per-bit parameter; no external baud tick is used.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2 or more.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  permits fetching new bytes from the FIFO
fifo_empty  in  1  FIFO EMPTY flag
fifo_data  in  8  FIFO dataOut, updated on the edge where the read is accepted
fifo_rd_en  out  1  FIFO readEn; high for exactly one cycle per byte
tx  out  1  serial line, idle high
busy  out  1  high from the FETCH state through the end of the last stop bit
tx_done  out  1  one-cycle pulse in the last cycle of the final stop bit

Behaviour:
- Reset: synchronous and active-high, as already decided; the clock port is named clk and the reset port is named reset.
- Reset values: tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE, bit counter=0, clock counter=0.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If enable=1 and fifo_empty=0, go to FETCH.
- FETCH: lasts one cycle with fifo_rd_en=1. The FIFO updates fifo_data at the end of this cycle. Go to LOAD.
- LOAD: lasts one cycle with fifo_rd_en=0. Latch fifo_data into the shift register and compute the parity bit (even: XOR of the data bits; odd: its inverse). Go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit counter tracks the bit index. After bit 7, go to PARITY if PARITY is nonzero, otherwise go to STOP.
- PARITY: tx=parity bit for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done pulses in the final cycle. The next state is then decided:
  - FETCH if enable=1 and fifo_empty=0 (back-to-back frames);
  - IDLE otherwise.
- Clock counter: width $clog2(CLKS_PER_BIT). It restarts at 0 on every state or bit change and never wraps mid-bit.
- Latency: 2 cycles from IDLE detecting a byte to the start-bit falling edge (FETCH, LOAD). The gap between back-to-back frames is 2 idle-high cycles.
- fifo_rd_en is never asserted while fifo_empty=1; it is only asserted for a byte that was present when sampled.
- enable falling mid-frame: the current frame completes unchanged and no new fetch follows.
- Bytes written to the FIFO mid-frame do not disturb the shift register; they are picked up at the end of STOP.
- Reset mid-frame: on the next edge, tx=1 and state=IDLE. The in-flight byte is lost and no fifo_rd_en is issued during reset.
- fifo_data is ignored in every state except LOAD.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, FETCH, LOAD, START, DATA, PARITY, STOP);
  - parity encoding constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - the frame data width constant (8).
- One sub-module, uart_bit_timer: counts to CLKS_PER_BIT-1 and emits a bit_end pulse. It has a synchronous clear, asserted by the FSM on state entry.

Test Plan:
- Single byte, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, FIFO holds 0xA5 -> fifo_rd_en high for 1 cycle; start edge 2 cycles later; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total); tx_done pulses once; busy returns to 0.
- Back-to-back, FIFO holds 0x00 then 0xFF -> two frames separated by exactly 2 high cycles; exactly 2 fifo_rd_en pulses; FIFO EMPTY afterwards.
- Parity: PARITY=1 sending 0x07 -> parity bit 1. PARITY=2 sending 0x07 -> parity bit 0. STOP_BITS=2 -> stop high for 8 cycles.
- Empty/enable: fifo_empty=1 with enable=1 -> no fifo_rd_en and tx stays 1. Drop enable during DATA of the first of 3 queued bytes -> the frame completes and the 2 remaining bytes stay in the FIFO.
- Reset in bit 4 of a frame -> tx=1 on the next edge; fifo_rd_en=0 throughout reset. After reset is released, the next queued byte is sent as a full, correct frame.
- Wrap-around: 20 bytes pushed through the 8-entry FIFO, with refills while transmitting -> all 20 bytes received in order by a bench UART monitor with no gaps or duplicates.
